// File: rtl/divi_ctrl_if.sv
// ----------------------------------------------------------------------------
// divi_ctrl_if
// Groups the operand input handshake, the divider-core operand/result bus and
// the result output handshake used by divi_ctrl.
//   slave  : the divi_ctrl side (drives in_ready, div_dividend/divisor, out_*)
//   master : the environment side (operand producer, divider core, consumer)
// Signals:
//   in_valid/in_ready/in_dividend/in_divisor/in_tag   operand pair handshake
//   div_dividend/div_divisor                           registered operands to core
//   div_rfd/div_quotient/div_fractional                core status and result
//   out_valid/out_ready/out_quotient/out_fractional/
//   out_tag/out_dbz                                    in-order result handshake
// ----------------------------------------------------------------------------
interface divi_ctrl_if #(
  parameter int DVD_W = 25,
  parameter int DVS_W = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [DVD_W-1:0] in_dividend;
  logic [DVS_W-1:0] in_divisor;
  logic [TAG_W-1:0] in_tag;

  logic [DVD_W-1:0] div_dividend;
  logic [DVS_W-1:0] div_divisor;
  logic             div_rfd;
  logic [DVD_W-1:0] div_quotient;
  logic [DVS_W-1:0] div_fractional;

  logic             out_valid;
  logic             out_ready;
  logic [DVD_W-1:0] out_quotient;
  logic [DVS_W-1:0] out_fractional;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;

  modport slave (
    input  in_valid, in_dividend, in_divisor, in_tag,
    output in_ready,
    output div_dividend, div_divisor,
    input  div_rfd, div_quotient, div_fractional,
    output out_valid, out_quotient, out_fractional, out_tag, out_dbz,
    input  out_ready
  );

  modport master (
    output in_valid, in_dividend, in_divisor, in_tag,
    input  in_ready,
    input  div_dividend, div_divisor,
    output div_rfd, div_quotient, div_fractional,
    input  out_valid, out_quotient, out_fractional, out_tag, out_dbz,
    output out_ready
  );
endinterface

// File: rtl/divi_ctrl.sv
// ----------------------------------------------------------------------------
// divi_ctrl
// Operand issue and result alignment for a pipelined divider core with a fixed
// latency. Operand pairs are accepted on a valid/ready handshake, registered
// towards the core, and tracked through a DIV_LAT-stage valid/tag/dbz delay
// line. When an op leaves the delay line the core result is captured into a
// first-word-fall-through FIFO and returned in issue order.
// Issue is credit based: an op is only accepted when the ops in flight plus
// the ops already queued leave room in the FIFO, so output backpressure never
// loses a result and the core is never stalled.
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        divi_ctrl_if.slave (operand in, core bus, result out)
//   inflight   ops issued to the core but not yet captured in the FIFO
// ----------------------------------------------------------------------------
module divi_ctrl #(
  parameter int DVD_W      = 25,
  parameter int DVS_W      = 16,
  parameter int TAG_W      = 4,
  parameter int DIV_LAT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  divi_ctrl_if.slave                  bus,
  output logic [$clog2(FIFO_DEPTH):0] inflight
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] fractional;
    logic [TAG_W-1:0] tag;
    logic             dbz;
  } entry_t;

  // Operand registers towards the core
  logic [DVD_W-1:0] r_div_dividend;
  logic [DVS_W-1:0] r_div_divisor;
  // Goes high on the first edge after reset release; keeps in_ready low in reset
  logic             r_active;

  // Delay line matching the core latency
  logic [DIV_LAT-1:0] r_dl_vld;
  logic [DIV_LAT-1:0] r_dl_dbz;
  logic [TAG_W-1:0]   r_dl_tag [DIV_LAT];

  // Output FIFO
  entry_t           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_inflight;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_out_valid;
  logic             w_pop;
  logic [CNT_W:0]   w_credit_sum;
  entry_t           w_push_entry;
  entry_t           w_head;

  // Every accepted op owns one FIFO slot from accept until it is popped, so
  // inflight + count can never exceed the FIFO depth.
  assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_in_ready   = r_active && bus.div_rfd && (w_credit_sum < DEPTH_SUM);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_capture    = r_dl_vld[DIV_LAT-1];
  assign w_out_valid  = (r_count != '0);
  assign w_pop        = w_out_valid && bus.out_ready;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_active       <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_accept) begin
        r_div_dividend <= bus.in_dividend;
        r_div_divisor  <= bus.in_divisor;
      end
    end
  end

  // Delay line: stage 0 loads on accept, the last stage marks the edge at which
  // the core result for that op is stable.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dl_vld <= '0;
      r_dl_dbz <= '0;
      for (int i = 0; i < DIV_LAT; i++) r_dl_tag[i] <= '0;
    end else begin
      r_dl_vld[0] <= w_accept;
      r_dl_dbz[0] <= (bus.in_divisor == '0);
      r_dl_tag[0] <= bus.in_tag;
      for (int i = 1; i < DIV_LAT; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_dbz[i] <= r_dl_dbz[i-1];
        r_dl_tag[i] <= r_dl_tag[i-1];
      end
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_push_entry     = '0;
    w_push_entry.tag = r_dl_tag[DIV_LAT-1];
    w_push_entry.dbz = r_dl_dbz[DIV_LAT-1];
    if (r_dl_dbz[DIV_LAT-1]) begin
      // Core output is meaningless for a zero divisor
      w_push_entry.quotient   = '1;
      w_push_entry.fractional = '0;
    end else begin
      w_push_entry.quotient   = bus.div_quotient;
      w_push_entry.fractional = bus.div_fractional;
    end
  end

  // NOTE: the FIFO storage has no reset; an entry is only observed after it
  // has been written, and the outputs are forced to zero while empty.
  always_ff @(posedge sys_clk) begin
    if (w_capture) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      if (w_capture) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case ({w_accept, w_capture})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.in_ready       = w_in_ready;
  assign bus.div_dividend   = r_div_dividend;
  assign bus.div_divisor    = r_div_divisor;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_quotient   = w_out_valid ? w_head.quotient   : '0;
  assign bus.out_fractional = w_out_valid ? w_head.fractional : '0;
  assign bus.out_tag        = w_out_valid ? w_head.tag        : '0;
  assign bus.out_dbz        = w_out_valid ? w_head.dbz        : 1'b0;
  assign inflight           = r_inflight;

  // Credits make this unreachable; firing means the credit accounting broke.
  a_no_overflow: assert property (
    @(posedge sys_clk) disable iff (!sys_rst_n)
      !(w_capture && (r_count == DEPTH_CNT))
  );

endmodule

// File: tb/tb_divi_ctrl.sv
module tb_divi_ctrl;
  localparam int DVD_W      = 25;
  localparam int DVS_W      = 16;
  localparam int TAG_W      = 4;
  localparam int DIV_LAT    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] inflight;

  divi_ctrl_if #(.DVD_W(DVD_W), .DVS_W(DVS_W), .TAG_W(TAG_W)) bus ();

  divi_ctrl #(
    .DVD_W(DVD_W), .DVS_W(DVS_W), .TAG_W(TAG_W),
    .DIV_LAT(DIV_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus),
    .inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider core stand-in: result for the operands registered at edge E0 is
  // stable after edge E0+DIV_LAT-1. A zero divisor yields junk on purpose.
  logic [DVD_W-1:0] cp_dvd [DIV_LAT-1];
  logic [DVS_W-1:0] cp_dvs [DIV_LAT-1];
  always @(posedge clk) begin
    cp_dvd[0] <= bus.div_dividend;
    cp_dvs[0] <= bus.div_divisor;
    for (int i = 1; i < DIV_LAT-1; i++) begin
      cp_dvd[i] <= cp_dvd[i-1];
      cp_dvs[i] <= cp_dvs[i-1];
    end
  end
  assign bus.div_quotient   = (cp_dvs[DIV_LAT-2] == '0) ? 25'h0155AA
                            : cp_dvd[DIV_LAT-2] / DVD_W'(cp_dvs[DIV_LAT-2]);
  assign bus.div_fractional = (cp_dvs[DIV_LAT-2] == '0) ? 16'h5A5A
                            : DVS_W'(cp_dvd[DIV_LAT-2] % DVD_W'(cp_dvs[DIV_LAT-2]));

  // Reference model: every accepted op is a pending result that becomes
  // visible DIV_LAT edges after its accept edge and leaves when consumed.
  typedef struct {
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] f;
    logic [TAG_W-1:0] tag;
    logic             dbz;
    int               cap;
  } exp_t;

  exp_t             scb[$];
  int               edge_n    = 0;
  bit               ready_ok  = 0;
  logic [DVD_W-1:0] last_dvd  = '0;
  logic [DVS_W-1:0] last_dvs  = '0;
  int               n_checks  = 0;
  int               n_bad     = 0;
  int               n_dut_acc = 0;
  int               n_dut_pop = 0;
  int               n_stall   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, compare, cross the rising edge,
  // update the model, return at the next falling edge.
  task automatic step(input logic v, input logic [DVD_W-1:0] dvd, input logic [DVS_W-1:0] dvs,
                      input logic [TAG_W-1:0] tag, input logic rfd, input logic ordy);
    bit   exp_rdy, exp_ov, acc, pop;
    int   infl;
    exp_t e;
    bus.in_valid    = v;
    bus.in_dividend = dvd;
    bus.in_divisor  = dvs;
    bus.in_tag      = tag;
    bus.div_rfd     = rfd;
    bus.out_ready   = ordy;
    #1;
    exp_rdy = ready_ok && rfd && (scb.size() < FIFO_DEPTH);
    exp_ov  = (scb.size() != 0) && (scb[0].cap <= edge_n);
    infl = 0;
    foreach (scb[i]) if (scb[i].cap > edge_n) infl++;
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    check("inflight", 64'(inflight), 64'(infl));
    check("div_dividend", 64'(bus.div_dividend), 64'(last_dvd));
    check("div_divisor", 64'(bus.div_divisor), 64'(last_dvs));
    if (exp_ov) begin
      check("out_quotient", 64'(bus.out_quotient), 64'(scb[0].q));
      check("out_fractional", 64'(bus.out_fractional), 64'(scb[0].f));
      check("out_tag", 64'(bus.out_tag), 64'(scb[0].tag));
      check("out_dbz", 64'(bus.out_dbz), 64'(scb[0].dbz));
    end
    if (v && bus.in_ready === 1'b1) n_dut_acc++;
    if (v && rfd && bus.in_ready !== 1'b1) n_stall++;
    if (ordy && bus.out_valid === 1'b1) n_dut_pop++;
    acc = v && exp_rdy;
    pop = exp_ov && ordy;
    if (acc) begin
      e.dbz = (dvs == 0);
      e.q   = e.dbz ? {DVD_W{1'b1}} : dvd / DVD_W'(dvs);
      e.f   = e.dbz ? '0 : DVS_W'(dvd % DVD_W'(dvs));
      e.tag = tag;
    end
    @(posedge clk);
    edge_n++;
    if (pop) void'(scb.pop_front());
    if (acc) begin
      e.cap = edge_n + DIV_LAT;
      scb.push_back(e);
      last_dvd = dvd;
      last_dvs = dvs;
    end
    ready_ok = 1;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, '0, 1'b1, ordy);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) idle(1'b1);
  endtask

  // Idles with out_ready low until a result shows; bounded by a cycle budget.
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 30) begin
      idle(1'b0);
      n++;
    end
    check("wait_valid", 64'(bus.out_valid), 64'(1));
  endtask

  initial begin
    int n, base, base2;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.in_tag      = '0;
    bus.div_rfd     = 1'b1;
    bus.out_ready   = 1'b0;
    #1;
    // Reset state
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_inflight", 64'(inflight), 64'(0));
    check("rst_div_dividend", 64'(bus.div_dividend), 64'(0));
    check("rst_div_divisor", 64'(bus.div_divisor), 64'(0));
    check("rst_out_quotient", 64'(bus.out_quotient), 64'(0));
    check("rst_out_tag", 64'(bus.out_tag), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);

    // 1: single op 120/10 tag 3; latency counted including the accept edge
    step(1'b1, 25'd120, 16'd10, 4'd3, 1'b1, 1'b0);
    wait_valid(n);
    check("t1_latency", 64'(n + 1), 64'(DIV_LAT + 1));
    check("t1_quotient", 64'(bus.out_quotient), 64'(12));
    check("t1_fractional", 64'(bus.out_fractional), 64'(0));
    check("t1_tag", 64'(bus.out_tag), 64'(3));
    check("t1_dbz", 64'(bus.out_dbz), 64'(0));
    idle(1'b1);
    idle(1'b1);
    check("t1_inflight_zero", 64'(inflight), 64'(0));
    check("t1_empty", 64'(bus.out_valid), 64'(0));

    // 2: 16 back-to-back ops with full throughput
    base  = n_stall;
    base2 = n_dut_pop;
    for (int i = 0; i < 16; i++)
      step(1'b1, DVD_W'(i*7 + 1), DVS_W'(i + 1), TAG_W'(i), 1'b1, 1'b1);
    check("t2_no_stall", 64'(n_stall - base), 64'(0));
    drain(DIV_LAT + 4);
    check("t2_results", 64'(n_dut_pop - base2), 64'(16));

    // 3: divide by zero, then a normal op
    step(1'b1, 25'd55, 16'd0, 4'd9, 1'b1, 1'b0);
    step(1'b1, 25'd9, 16'd3, 4'd10, 1'b1, 1'b0);
    wait_valid(n);
    check("t3_dbz_quotient", 64'(bus.out_quotient), 64'(25'h1FFFFFF));
    check("t3_dbz_fractional", 64'(bus.out_fractional), 64'(0));
    check("t3_dbz_flag", 64'(bus.out_dbz), 64'(1));
    check("t3_dbz_tag", 64'(bus.out_tag), 64'(9));
    idle(1'b1);
    wait_valid(n);
    check("t3_next_quotient", 64'(bus.out_quotient), 64'(3));
    check("t3_next_tag", 64'(bus.out_tag), 64'(10));
    check("t3_next_dbz", 64'(bus.out_dbz), 64'(0));
    drain(2);

    // 4: output stalled -> exactly FIFO_DEPTH accepts, then drain in order
    base = n_dut_acc;
    for (int i = 0; i < 20; i++)
      step(1'b1, DVD_W'(i*3 + 5), DVS_W'(i + 2), TAG_W'(i), 1'b1, 1'b0);
    check("t4_accepts", 64'(n_dut_acc - base), 64'(FIFO_DEPTH));
    check("t4_in_ready_low", 64'(bus.in_ready), 64'(0));
    base2 = n_dut_pop;
    for (int i = 0; i < 12; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    check("t4_pops", 64'(n_dut_pop - base2), 64'(FIFO_DEPTH));
    base = n_dut_acc;
    step(1'b1, 25'd77, 16'd7, 4'd1, 1'b1, 1'b1);
    check("t4_resume", 64'(n_dut_acc - base), 64'(1));
    drain(DIV_LAT + 3);

    // 5: core not ready for 3 cycles mid-stream
    for (int i = 0; i < 4; i++) step(1'b1, DVD_W'(1000 + i), DVS_W'(3 + i), TAG_W'(i), 1'b1, 1'b1);
    base = n_dut_acc;
    for (int i = 0; i < 3; i++) step(1'b1, DVD_W'(2000 + i), DVS_W'(5), TAG_W'(4 + i), 1'b0, 1'b1);
    check("t5_no_accept", 64'(n_dut_acc - base), 64'(0));
    for (int i = 0; i < 4; i++) step(1'b1, DVD_W'(3000 + i), DVS_W'(9), TAG_W'(8 + i), 1'b1, 1'b1);
    drain(DIV_LAT + 4);

    // 6: reset with 3 ops in flight and 2 queued
    step(1'b1, 25'd40, 16'd2, 4'd1, 1'b1, 1'b0);
    step(1'b1, 25'd41, 16'd2, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    step(1'b1, 25'd42, 16'd2, 4'd3, 1'b1, 1'b0);
    step(1'b1, 25'd43, 16'd2, 4'd4, 1'b1, 1'b0);
    step(1'b1, 25'd44, 16'd2, 4'd5, 1'b1, 1'b0);
    check("t6_pre_inflight", 64'(inflight), 64'(3));
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_out_valid", 64'(bus.out_valid), 64'(0));
    check("t6_in_ready", 64'(bus.in_ready), 64'(0));
    check("t6_inflight", 64'(inflight), 64'(0));
    scb.delete();
    ready_ok = 0;
    last_dvd = '0;
    last_dvs = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    step(1'b1, 25'd100, 16'd4, 4'd6, 1'b1, 1'b0);
    wait_valid(n);
    check("t6_quotient", 64'(bus.out_quotient), 64'(25));
    check("t6_tag", 64'(bus.out_tag), 64'(6));
    drain(2);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [DVD_W-1:0] dvd;
      logic [DVS_W-1:0] dvs;
      dvd = DVD_W'($urandom);
      if ($urandom_range(0, 7) == 0)      dvs = '0;
      else if ($urandom_range(0, 1) == 0) dvs = DVS_W'($urandom_range(1, 300));
      else                                dvs = DVS_W'($urandom);
      step($urandom_range(0, 3) != 0, dvd, dvs, TAG_W'($urandom),
           $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
    end
    drain(FIFO_DEPTH + DIV_LAT + 4);
    check("final_empty", 64'(bus.out_valid), 64'(0));
    check("final_inflight", 64'(inflight), 64'(0));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
